// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default geometry.
// Imported by the fetch unit, its queue and the bench.
package fetch_pkg;

    localparam int          INSTR_W_DEF  = 16;
    localparam int          PC_W_DEF     = 16;
    localparam int          ADDR_W_DEF   = 8;
    localparam int unsigned RESET_PC_DEF = 0;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// IMEM request/response and decode-side valid/ready bundle.
// master = fetch unit, slave = memory plus decode.
interface fetch_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int ADDR_W  = 8
);

    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Power-of-two depth: pointers wrap naturally, count tracks fullness.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  T                           i_data,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush;

    // Storage carries no reset; only pointers and count do.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one in-flight IMEM read, queue, redirect.
// Credit counts queued plus in-flight entries, net of this cycle's pop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          INSTR_W  = INSTR_W_DEF,
    parameter int          PC_W     = PC_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    fetch_if.master         bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = CW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_unit: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    logic [OW-1:0]   w_occ;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_credit;
    logic            w_issue;
    entry_t          w_in;
    entry_t          w_head;

    assign w_valid  = (w_count != '0);
    assign w_pop    = w_valid & bus.out_ready;
    assign w_push   = r_inflight & ~redirect_valid;
    assign w_occ    = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
    assign w_credit = (w_occ < OW'(DEPTH));
    assign w_issue  = reset_n & fetch_en & ~redirect_valid & w_credit;

    assign w_in.pc    = r_inflight_pc;
    assign w_in.instr = bus.imem_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc          <= PC_W'(RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + PC_W'(1);
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Empty queue drives fixed values so stale storage never leaks out.
    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = r_pc[ADDR_W-1:0];
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? w_head.pc : '0;
    assign bus.out_instr = w_valid ? w_head.instr : INSTR_W'(NOP_INSTR);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit for the 4-stage pipeline. It replaces the free-running PC and combinational IMEM read with four features: a synchronous-read instruction memory port, a small fetch queue, a valid/ready handshake toward decode, and a redirect input for branches and jumps. The unit sits between the instruction memory and the decode stage, and it supports back-pressure, fetch gating and squashing of wrong-path instructions.

## Interface
- `INSTR_W`, 16: instruction width in bits.
- `PC_W`, 16: PC width in bits; the PC is word-addressed.
- `ADDR_W`, 8: IMEM address width; `imem_addr` is `pc[ADDR_W-1:0]`.
- `DEPTH`, 2: fetch queue depth; must be ≥2 and a power of two.
- `RESET_PC`, 0: PC value loaded at reset.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `fetch_en`  in  1  high allows new IMEM requests.
- `redirect_valid`  in  1  a taken branch/jump resolved downstream.
- `redirect_pc`  in  PC_W  redirect target.
- `imem_en`  out  1  read request this cycle.
- `imem_addr`  out  ADDR_W  read address.
- `imem_rdata`  in  INSTR_W  read data, valid exactly 1 cycle after `imem_en`.
- `out_valid`  out  1  the queue head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_pc`  out  PC_W  PC of the head instruction.
- `out_instr`  out  INSTR_W  head instruction.

## Operation
- **Registered state:**
  - `pc`, the next fetch address.
  - `inflight` (1 bit), meaning an IMEM read was issued last cycle.
  - `inflight_pc`.
  - The queue, holding entries of {pc, instr}, with `count` from 0 to DEPTH.
- **Pop:** `pop = out_valid & out_ready`.
- **Issue:** `imem_en = fetch_en & ~redirect_valid & (count + inflight - pop < DEPTH)`.
  - The term is evaluated combinationally, pop-aware.
  - On issue: `pc <= pc + 1`, which wraps modulo 2^PC_W; `inflight <= 1`; `inflight_pc <= pc`.
- **Response:** in a cycle where `inflight=1` and `redirect_valid=0`, the entry {inflight_pc, imem_rdata} is pushed into the queue at the end of the cycle. The credit rule guarantees a push never overflows.
- **Redirect**, when `redirect_valid=1` in cycle t:
  - The queue is cleared and any response arriving in cycle t is discarded.
  - No issue occurs in cycle t.
  - `pc <= redirect_pc`.
  - A pop in cycle t still counts as consumed by decode. The queue is emptied regardless.
- **Simultaneous events:**
  - Redirect has priority over issue, push and fetch_en.
  - Push and pop in the same cycle leave `count` unchanged.
- **`fetch_en` low:** no new issue. An outstanding response is still pushed. The queue drains normally.
- **Output:** the head is stable while `out_valid & ~out_ready`. `out_pc` and `out_instr` must not change until the head is popped or a redirect occurs.
- **Empty queue:** `out_valid=0`. The `out_pc` and `out_instr` values are don't-care but must be driven, with no X propagation beyond the queue storage.

## Timing
- **Reset** (`reset_n=0` at a rising edge):
  - `pc=RESET_PC`, `inflight=0`, `count=0`.
  - `out_valid=0`, and `imem_en` is gated to 0 during reset.
  - Reset mid-operation drops all queued and in-flight entries. The IMEM response that lands after reset is ignored.
- **Fetch-to-output latency:** 2 cycles. An issue in cycle n gives data in cycle n+1, queued at the end of n+1, with `out_valid` in cycle n+2.
- **Throughput:** 1 instruction per cycle sustained when `out_ready=1` and `DEPTH≥2`.
- **Redirect in cycle t:**
  - First issue to `redirect_pc` is in cycle t+1.
  - First `out_valid` for the target is in cycle t+3.
  - The redirect penalty is therefore 3 cycles.
- **Back-pressure:** with `out_ready=0` the queue fills to DEPTH, then `imem_en` stays 0. Issue resumes in the same cycle `out_ready` rises.

## Structure
- **Shared package `fetch_pkg`:** default widths (`INSTR_W`, `PC_W`, `ADDR_W`), `RESET_PC`, the NOP encoding (16'h0000), and the `fetch_entry_t` struct {pc, instr}.
- **Sub-module `fetch_queue`:** a synchronous FIFO of `fetch_entry_t`, DEPTH entries, with push/pop/flush, `count`, and head output. It uses wrap-around pointers with log2(DEPTH) bits plus a separate count.
- **Top level:** PC register, in-flight tracking, credit logic and redirect priority.
- **Bench memory:** a simple synchronous-read `imem` model (256×16), preloaded with LOAD r1,10 = 0210, LOAD r2,20 = 0420, ADD = 0C9A, SUB = 1A91, and zeros elsewhere.

## Test plan
- **Reset release, out_ready=1, fetch_en=1:** `out_valid` first rises 2 cycles after release. It yields (pc,instr) = (0,0210), (1,0420), (2,0C9A), (3,1A91), (4,0000) on consecutive cycles with no bubbles.
- **Back-pressure:** `out_ready=0` from cycle 3 for 5 cycles.
  - Head (0,0210) is held stable and `count` reaches 2.
  - `imem_en` stays 0 after that.
  - On release, the sequence continues (1,0420)… with no loss or duplication.
- **Redirect:** `redirect_valid=1, redirect_pc=2` while entries for pc 1 and pc 2 are queued or in flight.
  - The queued and in-flight entries are dropped.
  - The next outputs are (2,0C9A), (3,1A91), the first appearing 3 cycles after the redirect.
- **Redirect coinciding with a response and with a pop:** the response is discarded. The popped head counts as accepted once. The next valid output is the redirect target.
- **fetch_en low for 4 cycles mid-stream:** no `imem_en`, the in-flight instruction is still delivered, and the PC sequence resumes without a gap.
- **Boundary behaviour:**
  - `reset_n=0` for one cycle mid-stream clears `out_valid` on the next cycle and restarts at (0,0210).
  - With `PC_W=8`, starting at pc 255 wraps to pc 0.
